// File: rtl/wm_pkg.sv
// Shared state encoding for the wash controller and its minute timer.
package wm_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 3'd0,
    ST_FILLING  = 3'd1,
    ST_WASHING  = 3'd2,
    ST_RINSING  = 3'd3,
    ST_SPINNING = 3'd4
  } wm_state_e;

endpackage

// File: rtl/wash_controller.sv
// Washing-machine sequencer: fill, wash, rinse, spin, driven by timer expiry flags.
// Define WM_DOUBLE_WASH_EN to enable the optional second wash/rinse pass.
module wash_controller
  import wm_pkg::*;
#(
  parameter int STATE_W = wm_pkg::STATE_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               coin_in,
  input  logic               double_wash,
  input  logic               timer_pause,
  input  logic               minutes_1,
  input  logic               minutes_2,
  input  logic               minutes_5,
  output logic [STATE_W-1:0] current_state,
  output logic               wash_done,
  output logic               busy
);

  wm_state_e r_state;
  logic      r_wash_done;
  logic      r_busy;

`ifdef WM_DOUBLE_WASH_EN
  logic      r_dw;
  logic      r_pass;
`else
  logic      w_unused_dw;
  assign w_unused_dw = double_wash;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_wash_done <= 1'b0;
      r_busy      <= 1'b0;
`ifdef WM_DOUBLE_WASH_EN
      r_dw        <= 1'b0;
      r_pass      <= 1'b0;
`endif
    end else begin
      r_wash_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (coin_in) begin
            r_state <= ST_FILLING;
            r_busy  <= 1'b1;
`ifdef WM_DOUBLE_WASH_EN
            r_dw    <= double_wash;
            r_pass  <= 1'b0;
`endif
          end
        end
        ST_FILLING: begin
          if (minutes_2) r_state <= ST_WASHING;
        end
        ST_WASHING: begin
          if (minutes_5) r_state <= ST_RINSING;
        end
        ST_RINSING: begin
          if (minutes_2) begin
`ifdef WM_DOUBLE_WASH_EN
            // Only one extra wash pass, then always on to spin.
            if (r_dw && !r_pass) begin
              r_state <= ST_WASHING;
              r_pass  <= 1'b1;
            end else begin
              r_state <= ST_SPINNING;
            end
`else
            r_state <= ST_SPINNING;
`endif
          end
        end
        ST_SPINNING: begin
          if (minutes_1 && !timer_pause) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_wash_done <= 1'b1;
          end
        end
        default: begin
          // Corrupt encodings recover silently, without a completion pulse.
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign current_state = STATE_W'(r_state);
  assign wash_done     = r_wash_done;
  assign busy          = r_busy;

endmodule

// File: tb/tb_wash_controller.sv
// Scoreboard bench for wash_controller: expected state/done/busy queued per applied vector.
module tb_wash_controller;

  logic       clk;
  logic       rst;
  logic       coin_in;
  logic       double_wash;
  logic       timer_pause;
  logic       minutes_1;
  logic       minutes_2;
  logic       minutes_5;
  logic [2:0] current_state;
  logic       wash_done;
  logic       busy;

  typedef struct {
    logic [2:0] st;
    logic       done;
    logic       busy;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  wash_controller #(.STATE_W(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .coin_in      (coin_in),
    .double_wash  (double_wash),
    .timer_pause  (timer_pause),
    .minutes_1    (minutes_1),
    .minutes_2    (minutes_2),
    .minutes_5    (minutes_5),
    .current_state(current_state),
    .wash_done    (wash_done),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector layout: {coin, dw, pause, m1, m2, m5} {expected state[2:0]} {expected wash_done}
  task automatic apply(input logic [9:0] v);
    {coin_in, double_wash, timer_pause, minutes_1, minutes_2, minutes_5} = v[9:4];
    sb_q.push_back('{st: v[3:1], done: v[0], busy: (v[3:1] != 3'd0)});
    @(posedge clk);
    #1;
    n_vec++;
  endtask

  task automatic test_reset();
    exp_t e;
    {coin_in, double_wash, timer_pause, minutes_1, minutes_2, minutes_5} = 6'b0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    n_vec++;
    if (current_state !== 3'd0 || wash_done !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_async: got state=%0d done=%b busy=%b, want state=0 done=0 busy=0",
               current_state, wash_done, busy);
    end
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    apply(10'b000000_000_0);
    e = sb_q.pop_front();
    if (current_state !== e.st || wash_done !== e.done || busy !== e.busy) begin
      n_err++;
      $display("FAIL reset_idle: got state=%0d done=%b busy=%b, want state=%0d done=%b busy=%b",
               current_state, wash_done, busy, e.st, e.done, e.busy);
    end
    $display("reset: state=%0d done=%b busy=%b", current_state, wash_done, busy);
  endtask

  task automatic test_normal();
    logic [9:0] tbl[$];
    exp_t e;
    tbl = '{10'b100000_001_0, 10'b000000_001_0, 10'b000010_010_0, 10'b000001_011_0,
            10'b000010_100_0, 10'b000100_000_1, 10'b000000_000_0};
    foreach (tbl[i]) begin
      apply(tbl[i]);
      e = sb_q.pop_front();
      if (current_state !== e.st || wash_done !== e.done || busy !== e.busy) begin
        n_err++;
        $display("FAIL normal[%0d]: got state=%0d done=%b busy=%b, want state=%0d done=%b busy=%b",
                 i, current_state, wash_done, busy, e.st, e.done, e.busy);
      end
      $display("normal[%0d]: in=%b state=%0d done=%b busy=%b", i, tbl[i][9:4], current_state, wash_done, busy);
    end
  endtask

  task automatic test_double_wash();
    logic [9:0] tbl[$];
    exp_t e;
`ifdef WM_DOUBLE_WASH_EN
    tbl = '{10'b110000_001_0, 10'b000010_010_0, 10'b000001_011_0, 10'b000010_010_0,
            10'b000001_011_0, 10'b000010_100_0, 10'b000100_000_1, 10'b000000_000_0};
`else
    tbl = '{10'b110000_001_0, 10'b000010_010_0, 10'b000001_011_0, 10'b000010_100_0,
            10'b000100_000_1, 10'b000000_000_0};
`endif
    foreach (tbl[i]) begin
      apply(tbl[i]);
      e = sb_q.pop_front();
      if (current_state !== e.st || wash_done !== e.done || busy !== e.busy) begin
        n_err++;
        $display("FAIL double_wash[%0d]: got state=%0d done=%b busy=%b, want state=%0d done=%b busy=%b",
                 i, current_state, wash_done, busy, e.st, e.done, e.busy);
      end
      $display("double_wash[%0d]: in=%b state=%0d done=%b busy=%b", i, tbl[i][9:4], current_state, wash_done, busy);
    end
  endtask

  task automatic test_pause();
    logic [9:0] tbl[$];
    exp_t e;
    tbl = '{10'b100000_001_0, 10'b000010_010_0, 10'b000001_011_0, 10'b000010_100_0,
            10'b001100_100_0, 10'b001100_100_0, 10'b001100_100_0, 10'b001000_100_0,
            10'b000100_000_1, 10'b000000_000_0};
    foreach (tbl[i]) begin
      apply(tbl[i]);
      e = sb_q.pop_front();
      if (current_state !== e.st || wash_done !== e.done || busy !== e.busy) begin
        n_err++;
        $display("FAIL pause[%0d]: got state=%0d done=%b busy=%b, want state=%0d done=%b busy=%b",
                 i, current_state, wash_done, busy, e.st, e.done, e.busy);
      end
      $display("pause[%0d]: in=%b state=%0d done=%b busy=%b", i, tbl[i][9:4], current_state, wash_done, busy);
    end
  endtask

  task automatic test_ignore_flags();
    logic [9:0] tbl[$];
    exp_t e;
    tbl = '{10'b100000_001_0, 10'b000100_001_0, 10'b000001_001_0, 10'b000010_010_0,
            10'b000100_010_0, 10'b000010_010_0, 10'b110010_010_0, 10'b001110_010_0,
            10'b000001_011_0, 10'b000001_011_0, 10'b000100_011_0, 10'b001000_011_0,
            10'b000010_100_0, 10'b000011_100_0, 10'b000100_000_1};
    foreach (tbl[i]) begin
      apply(tbl[i]);
      e = sb_q.pop_front();
      if (current_state !== e.st || wash_done !== e.done || busy !== e.busy) begin
        n_err++;
        $display("FAIL ignore[%0d]: got state=%0d done=%b busy=%b, want state=%0d done=%b busy=%b",
                 i, current_state, wash_done, busy, e.st, e.done, e.busy);
      end
      $display("ignore[%0d]: in=%b state=%0d done=%b busy=%b", i, tbl[i][9:4], current_state, wash_done, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] tbl[$];
    exp_t e;
    tbl = '{10'b100111_001_0, 10'b000010_010_0, 10'b000001_011_0, 10'b000010_100_0,
            10'b100100_000_1, 10'b100000_001_0, 10'b000010_010_0};
    foreach (tbl[i]) begin
      apply(tbl[i]);
      e = sb_q.pop_front();
      if (current_state !== e.st || wash_done !== e.done || busy !== e.busy) begin
        n_err++;
        $display("FAIL back_to_back[%0d]: got state=%0d done=%b busy=%b, want state=%0d done=%b busy=%b",
                 i, current_state, wash_done, busy, e.st, e.done, e.busy);
      end
      $display("back_to_back[%0d]: in=%b state=%0d done=%b busy=%b", i, tbl[i][9:4], current_state, wash_done, busy);
    end
  endtask

  // Entered with the machine in WASHING; reset lands mid-cycle.
  task automatic test_mid_reset();
    logic [9:0] tbl[$];
    exp_t e;
    {coin_in, double_wash, timer_pause, minutes_1, minutes_2, minutes_5} = 6'b000000;
    #3 rst = 1'b0;
    #1;
    n_vec++;
    if (current_state !== 3'd0 || wash_done !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset_async: got state=%0d done=%b busy=%b, want state=0 done=0 busy=0",
               current_state, wash_done, busy);
    end
    $display("mid_reset: state=%0d done=%b busy=%b", current_state, wash_done, busy);
    @(posedge clk);
    #1 rst = 1'b1;
    tbl = '{10'b000010_000_0, 10'b000101_000_0, 10'b000000_000_0};
    foreach (tbl[i]) begin
      apply(tbl[i]);
      e = sb_q.pop_front();
      if (current_state !== e.st || wash_done !== e.done || busy !== e.busy) begin
        n_err++;
        $display("FAIL post_reset[%0d]: got state=%0d done=%b busy=%b, want state=%0d done=%b busy=%b",
                 i, current_state, wash_done, busy, e.st, e.done, e.busy);
      end
      $display("post_reset[%0d]: in=%b state=%0d done=%b busy=%b", i, tbl[i][9:4], current_state, wash_done, busy);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_double_wash();
    test_pause();
    test_ignore_flags();
    test_back_to_back();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation still running at %0t, want finished", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/wash_controller.md
WASH_CONTROLLER -- requirements
Module: wash_controller

Interface
REQ-001 SHALL have parameter STATE_W, default 3, the width of the current_state encoding.
REQ-002 SHALL have port clk  input  1  the single system clock, rising-edge active.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port coin_in  input  1  a level that starts a cycle when sampled high in IDLE.
REQ-005 SHALL have port double_wash  input  1  a double-wash request, sampled with coin_in.
REQ-006 SHALL have port timer_pause  input  1  a user pause request, honoured only in SPINNING.
REQ-007 SHALL have port minutes_1  input  1  the timer's 1-minute expiry flag.
REQ-008 SHALL have port minutes_2  input  1  the timer's 2-minute expiry flag.
REQ-009 SHALL have port minutes_5  input  1  the timer's 5-minute expiry flag.
REQ-010 SHALL have port current_state  output  STATE_W  the registered FSM state that drives the timer.
REQ-011 SHALL have port wash_done  output  1  a registered one-cycle completion pulse.
REQ-012 SHALL have port busy  output  1  high whenever current_state is not IDLE.

Function
REQ-013 SHALL use the state encoding IDLE=0, FILLING=1, WASHING=2, RINSING=3, SPINNING=4.
REQ-014 SHALL move IDLE->FILLING on the first rising edge with coin_in=1, latching double_wash into dw_q and clearing pass_q.
REQ-015 SHALL move FILLING->WASHING on minutes_2=1 and WASHING->RINSING on minutes_5=1.
REQ-016 SHALL, in RINSING on minutes_2=1, move to WASHING and set pass_q=1 when dw_q=1 and pass_q=0; otherwise it SHALL move to SPINNING.
REQ-017 SHALL, in SPINNING, move to IDLE on minutes_1=1 only when timer_pause=0; while timer_pause=1 the state SHALL hold and minutes_1 SHALL be ignored.
REQ-018 SHALL, in each state, respond only to that state's own expiry flag; other flags, and timer_pause outside SPINNING, SHALL be ignored.
REQ-019 SHALL ignore coin_in and double_wash in every state other than IDLE.
REQ-020 SHALL assert wash_done for exactly one cycle: the first cycle in which current_state=IDLE after a SPINNING->IDLE transition.
REQ-021 SHALL give each transition one-cycle latency: a flag high at edge N changes current_state at edge N.
REQ-022 SHALL, in IDLE with coin_in=1 and any expiry flag also high, move to FILLING and nothing else.
REQ-023 SHALL send any encoding 5..7 to IDLE on the next edge without asserting wash_done.
REQ-024 SHALL be a Moore machine: all outputs registered, no combinational path from inputs to outputs.

Reset
REQ-025 SHALL, on rst=0, immediately force current_state=IDLE, wash_done=0, busy=0, dw_q=0 and pass_q=0, independent of clk.
REQ-026 SHALL, if reset asserts mid-cycle, abort the cycle with no wash_done pulse, then wait in IDLE for a new coin_in after release.

Configuration
REQ-027 SHALL, with macro WM_DOUBLE_WASH_EN defined, implement dw_q, pass_q and the RINSING->WASHING loop of REQ-016.
REQ-028 SHALL, with WM_DOUBLE_WASH_EN undefined, omit dw_q and pass_q, ignore double_wash, and always take RINSING->SPINNING on minutes_2.

Structure
REQ-029 SHALL take the state localparams and STATE_W from shared package wm_pkg, which the timer also uses.
REQ-030 SHALL be a single flat module with no sub-module.

Verification
REQ-031 Reset release, coin_in=1, double_wash=0 -> states 1,2,3,4,0 on minutes_2, minutes_5, minutes_2, minutes_1 pulses; wash_done=1 for exactly one cycle in IDLE.
REQ-032 coin_in=1, double_wash=1 (macro defined) -> states 1,2,3,2,3,4,0; only the second RINSING exits to SPINNING.
REQ-033 SPINNING with timer_pause=1 and minutes_1 pulsed 3 times -> state stays 4; timer_pause=0 plus minutes_1 -> state 0 and wash_done pulse.
REQ-034 WASHING with minutes_1 and minutes_2 pulses plus coin_in=1 -> state stays 2; minutes_5 -> state 3.
REQ-035 rst=0 asserted mid-WASHING between clock edges -> current_state=0 immediately, busy=0, no wash_done pulse.
REQ-036 Macro undefined with double_wash=1 -> sequence 1,2,3,4,0 with no repeated wash.
